// File: rtl/serial_burst_slave.sv
// Serial-bus slave: receives an addressed burst request over a single-wire bus,
// then performs write or read bursts against one local memory with a response timeout.
module serial_burst_slave #(
  parameter int                        SLAVE_ID_WIDTH = 3,
  parameter logic [SLAVE_ID_WIDTH-1:0] SELF_ID        = '0,
  parameter int                        ADDRESS_WIDTH  = 12,
  parameter int                        DATA_WIDTH     = 8,
  parameter int                        BURST_WIDTH    = 3,
  parameter int                        TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rd_wrt,
  input  logic                     bus_util,
  input  logic                     arbiter_cmd_in,
  input  logic                     module_dv,
  input  logic [DATA_WIDTH-1:0]    data_in_parallel,
  output logic                     write_en_internal,
  output logic                     req_int_data,
  output logic                     busy_out,
  output logic                     error_out,
  output logic [3:0]               state_out,
  output logic [DATA_WIDTH-1:0]    data_out_parallel,
  output logic [ADDRESS_WIDTH-1:0] addr_out,
  inout  wire                      data_bus_serial
);

  localparam int MAX_IA = (SLAVE_ID_WIDTH > ADDRESS_WIDTH) ? SLAVE_ID_WIDTH : ADDRESS_WIDTH;
  localparam int MAX_BD = (BURST_WIDTH > DATA_WIDTH) ? BURST_WIDTH : DATA_WIDTH;
  localparam int MAX_W  = (MAX_IA > MAX_BD) ? MAX_IA : MAX_BD;
  localparam int CNT_W  = $clog2(MAX_W + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 2);
  localparam int TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ID_RX     = 4'd1,
    WAIT_PEER = 4'd2,
    ADDR_RX   = 4'd3,
    LEN_RX    = 4'd4,
    ADDR_ACK  = 4'd5,
    WR_RX     = 4'd6,
    WR_MEM    = 4'd7,
    WR_DONE   = 4'd8,
    WR_ACK    = 4'd9,
    RD_REQ    = 4'd10,
    RD_MEM    = 4'd11,
    RD_GRANT  = 4'd12,
    RD_TX     = 4'd13
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [MAX_W-1:0]         shreg_q, shreg_d, shift_in;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [BURST_WIDTH-1:0]   len_q, len_d, idx_q, idx_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     rx_act_q, rx_act_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d, tx_q, tx_d;
  logic                     wr_en_q, wr_en_d, req_q, req_d, busy_q, busy_d, err_q, err_d;
  logic                     drive_en, drive_val, bus_in, mem_ok;

  assign bus_in          = data_bus_serial;
  assign data_bus_serial = drive_en ? drive_val : 1'bz;
  assign shift_in        = {shreg_q[MAX_W-2:0], bus_in};
  // The strobe cycle itself is never a valid response; dv counts from the next cycle on.
  assign mem_ok          = (tmo_q != '0) && module_dv;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      rx_act_q  <= 1'b0;
      wdata_q   <= '0;
      tx_q      <= '0;
      wr_en_q   <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      rx_act_q  <= rx_act_d;
      wdata_q   <= wdata_d;
      tx_q      <= tx_d;
      wr_en_q   <= wr_en_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    rx_act_d  = rx_act_q;
    wdata_d   = wdata_q;
    tx_d      = tx_q;
    wr_en_d   = 1'b0;
    req_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    drive_en  = 1'b0;
    drive_val = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus_in) begin
          state_d   = ID_RX;
          bit_cnt_d = '0;
        end
      end
      ID_RX: begin
        shreg_d   = shift_in;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(SLAVE_ID_WIDTH - 1)) begin
          bit_cnt_d = '0;
          state_d   = (shift_in[SLAVE_ID_WIDTH-1:0] == SELF_ID) ? ADDR_RX : WAIT_PEER;
        end
      end
      WAIT_PEER: begin
        if (bus_util) state_d = IDLE;
      end
      ADDR_RX: begin
        shreg_d   = shift_in;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(ADDRESS_WIDTH - 1)) begin
          bit_cnt_d = '0;
          base_d    = shift_in[ADDRESS_WIDTH-1:0];
          state_d   = LEN_RX;
        end
      end
      LEN_RX: begin
        shreg_d   = shift_in;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(BURST_WIDTH - 1)) begin
          bit_cnt_d = '0;
          len_d     = shift_in[BURST_WIDTH-1:0];
          idx_d     = '0;
          state_d   = ADDR_ACK;
        end
      end
      ADDR_ACK: begin
        drive_en = 1'b1;
        if (bit_cnt_q == '0) begin
          bit_cnt_d = CNT_W'(1);
        end else begin
          bit_cnt_d = '0;
          rx_act_d  = 1'b0;
          state_d   = rd_wrt ? WR_RX : RD_REQ;
        end
      end
      WR_RX: begin
        if (!rx_act_q) begin
          bit_cnt_d = '0;
          if (!bus_in) rx_act_d = 1'b1;
        end else begin
          shreg_d   = shift_in;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            rx_act_d  = 1'b0;
            wdata_d   = shift_in[DATA_WIDTH-1:0];
            wr_en_d   = 1'b1;
            busy_d    = 1'b1;
            tmo_d     = '0;
            state_d   = WR_MEM;
          end
        end
      end
      WR_MEM, RD_MEM: begin
        if (mem_ok) begin
          busy_d = 1'b0;
          if (state_q == RD_MEM) begin
            tx_d    = data_in_parallel;
            state_d = RD_GRANT;
          end else if (idx_q < len_q) begin
            idx_d   = idx_q + BURST_WIDTH'(1);
            state_d = WR_RX;
          end else begin
            state_d = WR_DONE;
          end
        end else if (TIMEOUT_CYCLES != 0 && tmo_q == TMO_W'(TMO_LAST)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = WAIT_PEER;
        end else if (tmo_q == '0 || TIMEOUT_CYCLES != 0) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WR_DONE: begin
        if (arbiter_cmd_in) begin
          bit_cnt_d = '0;
          state_d   = WR_ACK;
        end
      end
      WR_ACK: begin
        drive_en  = 1'b1;
        drive_val = (bit_cnt_q != '0);
        if (bit_cnt_q == '0) begin
          bit_cnt_d = CNT_W'(1);
        end else begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      RD_REQ: begin
        req_d   = 1'b1;
        busy_d  = 1'b1;
        tmo_d   = '0;
        state_d = RD_MEM;
      end
      RD_GRANT: begin
        if (arbiter_cmd_in) begin
          bit_cnt_d = '0;
          state_d   = RD_TX;
        end
      end
      RD_TX: begin
        drive_en  = 1'b1;
        drive_val = (bit_cnt_q == '0) ? 1'b0 : tx_q[DATA_WIDTH-1];
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q != '0) tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
        if (bit_cnt_q == CNT_W'(DATA_WIDTH)) begin
          bit_cnt_d = '0;
          if (idx_q < len_q) begin
            idx_d   = idx_q + BURST_WIDTH'(1);
            state_d = RD_REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign write_en_internal = wr_en_q;
  assign req_int_data      = req_q;
  assign busy_out          = busy_q;
  assign error_out         = err_q;
  assign state_out         = state_q;
  assign data_out_parallel = wdata_q;
  assign addr_out          = base_q + ADDRESS_WIDTH'(idx_q);

endmodule

// File: tb/tb_serial_burst_slave.sv
// Directed bench for serial_burst_slave: write/read bursts, ID mismatch, timeout, reset mid-read.
module tb_serial_burst_slave;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rd_wrt = 1'b0, bus_util = 1'b0, arbiter_cmd_in = 1'b0, module_dv = 1'b0;
  logic [7:0]  data_in_parallel = '0;
  logic        write_en_internal, req_int_data, busy_out, error_out;
  logic [3:0]  state_out;
  logic [7:0]  data_out_parallel;
  logic [11:0] addr_out;
  logic        m_en = 1'b0, m_val = 1'b1;
  wire         bus;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  int err_pulses = 0;

  assign bus = m_en ? m_val : 1'bz;
  pullup (bus);

  serial_burst_slave dut (
    .clk               (clk),
    .rstn              (rstn),
    .rd_wrt            (rd_wrt),
    .bus_util          (bus_util),
    .arbiter_cmd_in    (arbiter_cmd_in),
    .module_dv         (module_dv),
    .data_in_parallel  (data_in_parallel),
    .write_en_internal (write_en_internal),
    .req_int_data      (req_int_data),
    .busy_out          (busy_out),
    .error_out         (error_out),
    .state_out         (state_out),
    .data_out_parallel (data_out_parallel),
    .addr_out          (addr_out),
    .data_bus_serial   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_en_internal === 1'b1) wr_pulses++;
    if (error_out === 1'b1) err_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    m_en  = 1'b1;
    m_val = b;
    tick();
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic release_bus();
    m_en = 1'b0;
    #1;
  endtask

  task automatic request(input logic [2:0] id, input logic [11:0] addr, input logic [2:0] len);
    send_bit(1'b0);
    send_bits({29'd0, id}, 3);
    send_bits({20'd0, addr}, 12);
    send_bits({29'd0, len}, 3);
  endtask

  task automatic addr_ack(input logic wr);
    rd_wrt = wr;
    release_bus();
    check("ack0_state", 32'(state_out), 32'd5);
    check("ack0_bus", 32'(bus), 32'd0);
    tick();
    check("ack1_bus", 32'(bus), 32'd0);
    tick();
    check("ack_dir_state", 32'(state_out), wr ? 32'd6 : 32'd10);
    check("ack_release", 32'(bus), 32'd1);
  endtask

  task automatic write_word(input logic [11:0] addr, input logic [7:0] data, input logic last);
    send_bit(1'b0);
    send_bits({24'd0, data}, 8);
    release_bus();
    check("wr_strobe", 32'(write_en_internal), 32'd1);
    check("wr_addr", 32'(addr_out), 32'(addr));
    check("wr_data", 32'(data_out_parallel), 32'(data));
    check("wr_busy", 32'(busy_out), 32'd1);
    module_dv = 1'b1;
    tick();
    check("wr_dv_early_ignored", 32'(state_out), 32'd7);
    check("wr_strobe_1cyc", 32'(write_en_internal), 32'd0);
    tick();
    module_dv = 1'b0;
    check("wr_busy_clr", 32'(busy_out), 32'd0);
    check("wr_next_state", 32'(state_out), last ? 32'd8 : 32'd6);
  endtask

  task automatic write_finish();
    tick();
    check("wr_done_wait", 32'(state_out), 32'd8);
    arbiter_cmd_in = 1'b1;
    tick();
    arbiter_cmd_in = 1'b0;
    check("wr_ack0_state", 32'(state_out), 32'd9);
    check("wr_ack0_bus", 32'(bus), 32'd0);
    tick();
    check("wr_ack1_bus", 32'(bus), 32'd1);
    tick();
    check("wr_end_idle", 32'(state_out), 32'd0);
  endtask

  task automatic read_word(input logic [11:0] addr, input logic [7:0] data, input logic last);
    tick();
    check("rd_state_mem", 32'(state_out), 32'd11);
    check("rd_req", 32'(req_int_data), 32'd1);
    check("rd_busy", 32'(busy_out), 32'd1);
    check("rd_addr", 32'(addr_out), 32'(addr));
    data_in_parallel = data;
    module_dv = 1'b1;
    tick();
    check("rd_dv_early_ignored", 32'(state_out), 32'd11);
    check("rd_req_1cyc", 32'(req_int_data), 32'd0);
    tick();
    module_dv = 1'b0;
    data_in_parallel = 8'h00;
    check("rd_grant_state", 32'(state_out), 32'd12);
    check("rd_busy_clr", 32'(busy_out), 32'd0);
    tick();
    check("rd_grant_wait", 32'(state_out), 32'd12);
    arbiter_cmd_in = 1'b1;
    tick();
    arbiter_cmd_in = 1'b0;
    check("rd_tx_state", 32'(state_out), 32'd13);
    check("rd_tx_start", 32'(bus), 32'd0);
    for (int i = 7; i >= 0; i--) begin
      tick();
      check("rd_tx_bit", 32'(bus), 32'(data[i]));
    end
    tick();
    check("rd_after_tx", 32'(state_out), last ? 32'd0 : 32'd10);
    check("rd_tx_release", 32'(bus), 32'd1);
  endtask

  initial begin
    #3;
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_bus", 32'(bus), 32'd1);
    check("rst_outs", {busy_out, error_out, write_en_internal, req_int_data}, 32'd0);
    check("rst_addr", 32'(addr_out), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("idle_hold", 32'(state_out), 32'd0);

    // Single write at 0x123
    request(3'b000, 12'h123, 3'd0);
    addr_ack(1'b1);
    write_word(12'h123, 8'hA5, 1'b1);
    write_finish();
    check("single_wr_pulses", 32'(wr_pulses), 32'd1);

    // Write burst of four words
    request(3'b000, 12'h123, 3'd3);
    addr_ack(1'b1);
    write_word(12'h123, 8'h11, 1'b0);
    write_word(12'h124, 8'h22, 1'b0);
    write_word(12'h125, 8'h33, 1'b0);
    write_word(12'h126, 8'h44, 1'b1);
    write_finish();
    check("burst_wr_pulses", 32'(wr_pulses), 32'd5);

    // Read burst of two words wrapping past 0xFFF
    request(3'b000, 12'hFFF, 3'd1);
    addr_ack(1'b0);
    read_word(12'hFFF, 8'h5A, 1'b0);
    read_word(12'h000, 8'hC3, 1'b1);

    // ID mismatch: slave must stay silent until bus_util
    request(3'b101, 12'h000, 3'd0);
    release_bus();
    check("mismatch_state", 32'(state_out), 32'd2);
    check("mismatch_no_ack", 32'(bus), 32'd1);
    send_bits(32'h0000_0000, 8);
    release_bus();
    check("mismatch_ignored", 32'(state_out), 32'd2);
    check("mismatch_no_strobe", 32'(wr_pulses), 32'd5);
    bus_util = 1'b1;
    tick();
    bus_util = 1'b0;
    check("mismatch_released", 32'(state_out), 32'd0);

    // Timeout: module_dv withheld after a write strobe
    request(3'b000, 12'h200, 3'd0);
    addr_ack(1'b1);
    send_bit(1'b0);
    send_bits(32'h3C, 8);
    release_bus();
    check("tmo_strobe", 32'(write_en_internal), 32'd1);
    for (int k = 1; k < 16; k++) tick();
    check("tmo_not_yet", 32'(error_out), 32'd0);
    check("tmo_busy_hold", 32'(busy_out), 32'd1);
    check("tmo_state_hold", 32'(state_out), 32'd7);
    tick();
    check("tmo_error", 32'(error_out), 32'd1);
    check("tmo_busy_clr", 32'(busy_out), 32'd0);
    check("tmo_state", 32'(state_out), 32'd2);
    tick();
    check("tmo_error_1cyc", 32'(error_out), 32'd0);
    check("tmo_err_pulses", 32'(err_pulses), 32'd1);
    bus_util = 1'b1;
    tick();
    bus_util = 1'b0;
    check("tmo_recover", 32'(state_out), 32'd0);

    // Reset during RD_TX while the slave drives a 0
    request(3'b000, 12'h040, 3'd2);
    addr_ack(1'b0);
    tick();
    data_in_parallel = 8'h00;
    module_dv = 1'b1;
    tick();
    tick();
    module_dv = 1'b0;
    arbiter_cmd_in = 1'b1;
    tick();
    arbiter_cmd_in = 1'b0;
    tick();
    tick();
    check("pre_rst_state", 32'(state_out), 32'd13);
    check("pre_rst_bus", 32'(bus), 32'd0);
    rstn = 1'b0;
    #1;
    check("mid_rst_state", 32'(state_out), 32'd0);
    check("mid_rst_bus_z", 32'(bus), 32'd1);
    check("mid_rst_outs", {busy_out, error_out, write_en_internal, req_int_data}, 32'd0);
    check("mid_rst_addr", 32'(addr_out), 32'd0);
    tick();
    tick();
    check("rst_held_idle", 32'(state_out), 32'd0);
    rstn = 1'b1;
    tick();

    request(3'b000, 12'h055, 3'd0);
    addr_ack(1'b1);
    write_word(12'h055, 8'h7E, 1'b1);
    write_finish();
    check("post_rst_wr_pulses", 32'(wr_pulses), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
